axi_lite_slave_regs: RTL

- AXI4-Lite responder: a 4-word register file behind independent write (AW/W/B) and read (AR/R) channels.
- Answers the transactions issued by the team's AXI_Lite host-side master.
- Serves as the standalone slave endpoint for register-mapped peripherals on the Basys3 design.
- Registers slv_reg0..slv_reg3 sit at byte offsets 0x0, 0x4, 0x8, 0xC.

---
 rtl/axi_lite_slave_regs.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave with four 32-bit registers at 0x0/0x4/0x8/0xC. AXI_SLVERR_EN enables SLVERR for addresses >= 0x10.
// Write commits one edge after the second of AW/W is captured, and read data appears one edge after AR. B and R hold until READY.
module axi_lite_slave_regs #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic [ADDR_WIDTH-1:0]     AWADDR,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [DATA_WIDTH-1:0]     WDATA,
    input  logic [DATA_WIDTH/8-1:0]   WSTRB,
    input  logic                      WVALID,
    output logic                      WREADY,
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,
    input  logic [ADDR_WIDTH-1:0]     ARADDR,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    output logic [DATA_WIDTH-1:0]     RDATA,
    output logic [1:0]                RRESP,
    output logic                      RVALID,
    input  logic                      RREADY
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int         NBYTES      = DATA_WIDTH / 8;

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    w_state_t              w_state;
    r_state_t              r_state;
    logic [DATA_WIDTH-1:0] slv_reg [4];

    logic                  aw_held;
    logic                  w_held;
    logic [1:0]            aw_idx;
    logic                  aw_oor;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [NBYTES-1:0]     wstrb_q;

    logic                  aw_oor_in;
    logic                  ar_oor_in;
    logic                  aw_hs;
    logic                  w_hs;

`ifdef AXI_SLVERR_EN
    assign aw_oor_in = |AWADDR[ADDR_WIDTH-1:4];
    assign ar_oor_in = |ARADDR[ADDR_WIDTH-1:4];
    logic unused_addr_bits;
    assign unused_addr_bits = ^{AWADDR[1:0], ARADDR[1:0]};
`else
    // Upper address bits alias onto the four registers.
    assign aw_oor_in = 1'b0;
    assign ar_oor_in = 1'b0;
    logic unused_addr_bits;
    assign unused_addr_bits = ^{AWADDR[ADDR_WIDTH-1:4], AWADDR[1:0],
                                ARADDR[ADDR_WIDTH-1:4], ARADDR[1:0]};
`endif

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state <= W_IDLE;
            AWREADY <= 1'b1;
            WREADY  <= 1'b1;
            BVALID  <= 1'b0;
            BRESP   <= RESP_OKAY;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_idx  <= '0;
            aw_oor  <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            for (int i = 0; i < 4; i++) slv_reg[i] <= '0;
        end else begin
            case (w_state)
                W_IDLE, W_WAIT: begin
                    if (aw_held && w_held) begin
                        // Both halves captured on an earlier edge: commit now.
                        if (!aw_oor) begin
                            for (int k = 0; k < NBYTES; k++) begin
                                if (wstrb_q[k]) slv_reg[aw_idx][8*k +: 8] <= wdata_q[8*k +: 8];
                            end
                        end
                        BVALID  <= 1'b1;
                        BRESP   <= aw_oor ? RESP_SLVERR : RESP_OKAY;
                        w_state <= W_RESP;
                    end else begin
                        if (aw_hs) begin
                            aw_held <= 1'b1;
                            AWREADY <= 1'b0;
                            aw_idx  <= AWADDR[3:2];
                            aw_oor  <= aw_oor_in;
                        end
                        if (w_hs) begin
                            w_held  <= 1'b1;
                            WREADY  <= 1'b0;
                            wdata_q <= WDATA;
                            wstrb_q <= WSTRB;
                        end
                        if (aw_hs || w_hs || aw_held || w_held) w_state <= W_WAIT;
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        BVALID  <= 1'b0;
                        AWREADY <= 1'b1;
                        WREADY  <= 1'b1;
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Register reads use pre-edge contents, so a same-edge write is not visible.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= R_IDLE;
            ARREADY <= 1'b1;
            RVALID  <= 1'b0;
            RDATA   <= '0;
            RRESP   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ARVALID && ARREADY) begin
                        RDATA   <= ar_oor_in ? '0 : slv_reg[ARADDR[3:2]];
                        RRESP   <= ar_oor_in ? RESP_SLVERR : RESP_OKAY;
                        RVALID  <= 1'b1;
                        ARREADY <= 1'b0;
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (RREADY) begin
                        RVALID  <= 1'b0;
                        ARREADY <= 1'b1;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule
